bp_be_cache_req_arbiter: RTL and testbench
==========================================

Name: bp_be_cache_req_arbiter

Overview:
- Shares the single D$-to-LCE miss-request channel (cache_req, cache_req_metadata, cache_req_complete) between two BE requesters.
- Requester 0 is the dcache miss path; requester 1 is the page-table walker / uncached path.
- Sequences the full transaction: request, then metadata, then completion. Only one transaction is outstanding at a time, and the LCE sees a single coherent requester.
- Grants alternate round-robin between requesters.

Parameters:
req_width_p, 128, width of the cache request packet.
metadata_width_p, 8, width of the request metadata packet.

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  synchronous, active-low reset
req_i  in  2*req_width_p  request packets; slot k = bits [k*req_width_p +: req_width_p]
req_v_i  in  2  per-requester request valid
req_ready_o  out  2  per-requester request ready; transfer when v&ready
metadata_i  in  2*metadata_width_p  per-requester metadata packets
metadata_v_i  in  2  per-requester metadata valid
complete_o  out  2  one-cycle completion pulse to owning requester
cache_req_o  out  req_width_p  request to LCE
cache_req_v_o  out  1  request valid to LCE
cache_req_ready_i  in  1  LCE request ready
cache_req_metadata_o  out  metadata_width_p  metadata to LCE
cache_req_metadata_v_o  out  1  metadata valid to LCE (no ready; always accepted)
cache_req_complete_i  in  1  LCE transaction complete
busy_o  out  1  transaction in flight (state != e_idle)
owner_o  out  1  id of current/last granted requester

Behaviour:
- Reset (reset_i==0 at clock edge): state=e_idle, owner=0, last_grant=1 (so requester 0 wins the first tie).
  - While in reset, all outputs are 0: cache_req_v_o, cache_req_metadata_v_o, req_ready_o, complete_o, busy_o, owner_o.
  - A reset mid-transaction abandons the transaction silently; no complete_o pulse is produced.
- States: e_idle, e_meta, e_wait.
- e_idle:
  - Winner w = the only valid requester, or, if both are valid, ~last_grant.
  - Outputs are combinational: cache_req_o=req_i[w], cache_req_v_o=|req_v_i, req_ready_o[w]=cache_req_ready_i, req_ready_o[~w]=0.
  - On handshake (req_v_i[w] & cache_req_ready_i): owner<=w, last_grant<=w, state<=e_meta.
  - Zero-cycle pass-through latency.
  - Once cache_req_v_o is asserted with cache_req_ready_i low, w must not change unless requester w drops valid. Requesters must hold valid until served (bp ready/valid rule).
- e_meta:
  - req_ready_o=0 and cache_req_v_o=0.
  - cache_req_metadata_o=metadata_i[owner]; cache_req_metadata_v_o=metadata_v_i[owner].
  - On metadata_v_i[owner]: state<=e_wait.
  - metadata_v_i from the non-owner is ignored.
  - If metadata_v_i[owner] and cache_req_complete_i are both high in the same cycle: forward the metadata, pulse complete_o[owner] that cycle, state<=e_idle.
  - cache_req_complete_i without metadata in e_meta is a protocol error: simulation assertion fires and the state is unchanged.
- e_wait:
  - All readies and valids are 0.
  - On cache_req_complete_i: complete_o[owner]=1 combinationally in the same cycle, state<=e_idle.
- cache_req_complete_i in e_idle is ignored and flagged by a simulation assertion.
- Throughput: a new request is accepted no earlier than the cycle after complete. Minimum transaction occupancy is 3 cycles (req, meta, complete), or 2 cycles when meta and complete coincide.
- Fairness: after requester k is granted, requester ~k wins the next contention. Neither requester waits more than one transaction.
- busy_o=(state!=e_idle). owner_o holds the last granted id until the next grant.

Test Plan:
- Single request: after reset, req_v_i=01, req_i[0]=A, cache_req_ready_i=1.
  - Same cycle: cache_req_o=A, req_ready_o=01.
  - Next cycle: busy_o=1, owner_o=0.
  - metadata_v_i=01 with M0 -> cache_req_metadata_o=M0, metadata_v=1 for one cycle.
  - complete 2 cycles later -> complete_o=01 for exactly one cycle, then busy_o=0.
- Contention round-robin: req_v_i=11 held across four back-to-back transactions.
  - Grant order 0,1,0,1; owner_o toggles; complete_o pulses 01,10,01,10.
- Backpressure: req_v_i=10, cache_req_ready_i=0 for 5 cycles.
  - cache_req_v_o=1, req_ready_o=00 throughout, state stays e_idle.
  - Assert req_v_i[0] at cycle 3: winner stays 1; handshake happens when ready rises.
- Meta/complete coincide: in e_meta, metadata_v_i[owner]=1 and cache_req_complete_i=1 in the same cycle.
  - Metadata forwarded, complete_o pulses, e_idle next cycle; a new request is accepted the following cycle.
- Non-owner metadata: owner=0, metadata_v_i=10 -> cache_req_metadata_v_o=0, state remains e_meta.
- Reset mid-transaction: reset_i=0 in e_wait.
  - Next cycle: all outputs 0, busy_o=0, no complete_o.
  - After release with req_v_i=11, requester 0 is granted first.

Source files
------------

// File: rtl/bp_be_cache_req_arbiter_if.sv
// Bundle of the two BE requester lanes and the shared D$-to-LCE miss-request channel.
// The slave modport is the arbiter's view; the master modport is the requester/LCE side.
interface bp_be_cache_req_arbiter_if
  #(parameter int req_width_p      = 128
  , parameter int metadata_width_p = 8
  );

  logic [2*req_width_p-1:0]      req_i;
  logic [1:0]                    req_v_i;
  logic [1:0]                    req_ready_o;
  logic [2*metadata_width_p-1:0] metadata_i;
  logic [1:0]                    metadata_v_i;
  logic [1:0]                    complete_o;

  logic [req_width_p-1:0]        cache_req_o;
  logic                          cache_req_v_o;
  logic                          cache_req_ready_i;
  logic [metadata_width_p-1:0]   cache_req_metadata_o;
  logic                          cache_req_metadata_v_o;
  logic                          cache_req_complete_i;

  logic                          busy_o;
  logic                          owner_o;

  modport master
    (output req_i, req_v_i, metadata_i, metadata_v_i, cache_req_ready_i, cache_req_complete_i
    , input req_ready_o, complete_o, cache_req_o, cache_req_v_o
    , input cache_req_metadata_o, cache_req_metadata_v_o, busy_o, owner_o
    );

  modport slave
    (input req_i, req_v_i, metadata_i, metadata_v_i, cache_req_ready_i, cache_req_complete_i
    , output req_ready_o, complete_o, cache_req_o, cache_req_v_o
    , output cache_req_metadata_o, cache_req_metadata_v_o, busy_o, owner_o
    );

endinterface

// File: rtl/bp_be_cache_req_arbiter.sv
// Round-robin arbiter sharing the single LCE miss-request channel between two BE requesters,
// sequencing request -> metadata -> completion with one transaction outstanding.
module bp_be_cache_req_arbiter
  #(parameter int req_width_p      = 128
  , parameter int metadata_width_p = 8
  )
  (input logic                  clk_i
  , input logic                 reset_i
  , bp_be_cache_req_arbiter_if.slave bus
  );

  typedef enum logic [1:0] {e_idle, e_meta, e_wait} state_e;

  state_e state_r, state_n;
  logic   owner_r, owner_n;
  logic   last_grant_r, last_grant_n;
  logic   lock_v_r, lock_v_n;
  logic   lock_id_r, lock_id_n;
  logic   win;
  logic   meta_v_own;
  logic [metadata_width_p-1:0] meta_own;

  // A request stalled by LCE backpressure keeps the grant while its requester stays valid.
  always_comb begin
    if (lock_v_r && bus.req_v_i[lock_id_r])
      win = lock_id_r;
    else if (&bus.req_v_i)
      win = ~last_grant_r;
    else
      win = bus.req_v_i[1];
  end

  assign meta_v_own = bus.metadata_v_i[owner_r];
  assign meta_own   = owner_r ? bus.metadata_i[metadata_width_p +: metadata_width_p]
                              : bus.metadata_i[0 +: metadata_width_p];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r      <= e_idle;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      lock_v_r     <= 1'b0;
      lock_id_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      owner_r      <= owner_n;
      last_grant_r <= last_grant_n;
      lock_v_r     <= lock_v_n;
      lock_id_r    <= lock_id_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    owner_n      = owner_r;
    last_grant_n = last_grant_r;
    lock_v_n     = 1'b0;
    lock_id_n    = lock_id_r;
    case (state_r)
      e_idle: begin
        if (bus.req_v_i[win] && bus.cache_req_ready_i) begin
          owner_n      = win;
          last_grant_n = win;
          state_n      = e_meta;
        end else if (|bus.req_v_i) begin
          lock_v_n  = 1'b1;
          lock_id_n = win;
        end
      end
      e_meta: begin
        if (meta_v_own)
          state_n = bus.cache_req_complete_i ? e_idle : e_wait;
      end
      e_wait: begin
        if (bus.cache_req_complete_i)
          state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  // Every handshake output is forced low while reset is held, regardless of state.
  always_comb begin
    bus.cache_req_o            = win ? bus.req_i[req_width_p +: req_width_p]
                                     : bus.req_i[0 +: req_width_p];
    bus.cache_req_v_o          = 1'b0;
    bus.req_ready_o            = '0;
    bus.cache_req_metadata_o   = meta_own;
    bus.cache_req_metadata_v_o = 1'b0;
    bus.complete_o             = '0;
    if (reset_i) begin
      case (state_r)
        e_idle: begin
          bus.cache_req_v_o    = |bus.req_v_i;
          bus.req_ready_o[win] = bus.cache_req_ready_i;
        end
        e_meta: begin
          bus.cache_req_metadata_v_o = meta_v_own;
          bus.complete_o[owner_r]    = meta_v_own & bus.cache_req_complete_i;
        end
        e_wait: bus.complete_o[owner_r] = bus.cache_req_complete_i;
        default: ;
      endcase
    end
  end

  assign bus.busy_o  = reset_i & (state_r != e_idle);
  assign bus.owner_o = reset_i & owner_r;

  a_no_complete_in_idle: assert property (@(posedge clk_i) disable iff (!reset_i)
    (state_r == e_idle) |-> !bus.cache_req_complete_i);
  a_no_complete_before_meta: assert property (@(posedge clk_i) disable iff (!reset_i)
    ((state_r == e_meta) && bus.cache_req_complete_i) |-> meta_v_own);

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic, compared cycle by cycle
// against a transaction-level reference model of the arbiter.
module tb_bp_be_cache_req_arbiter;
  localparam int RW = 128;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_be_cache_req_arbiter_if #(.req_width_p(RW), .metadata_width_p(MW)) bus();

  bp_be_cache_req_arbiter #(.req_width_p(RW), .metadata_width_p(MW)) dut
    (.clk_i(clk), .reset_i(rst_n), .bus(bus));

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // requester and LCE stimulus, applied at the falling edge
  logic [1:0]    pend_v;
  logic [RW-1:0] pend_pkt [2];
  logic          d_rst, d_ready, d_cpl;
  logic [1:0]    d_meta_v;
  logic [MW-1:0] d_meta [2];

  // reference model: one optional in-flight transaction plus grant history
  bit m_active, m_got_meta;
  int m_owner, m_last, m_hold;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick_winner();
    if (m_hold >= 0 && pend_v[m_hold]) return m_hold;
    if (pend_v == 2'b11) return 1 - m_last;
    return pend_v[1] ? 1 : 0;
  endfunction

  task automatic new_req(input int k);
    pend_pkt[k] = {$urandom, $urandom, $urandom, $urandom};
    pend_v[k]   = 1'b1;
  endtask

  task automatic cycle();
    int w;
    logic any, exp_v, exp_mv;
    logic [1:0] exp_rdy, exp_cpl;
    @(negedge clk);
    rst_n                    = d_rst;
    bus.req_v_i              = pend_v;
    bus.req_i                = {pend_pkt[1], pend_pkt[0]};
    bus.cache_req_ready_i    = d_ready;
    bus.metadata_v_i         = d_meta_v;
    bus.metadata_i           = {d_meta[1], d_meta[0]};
    bus.cache_req_complete_i = d_cpl;
    #1;
    any     = |pend_v;
    w       = pick_winner();
    exp_v   = 1'b0;
    exp_mv  = 1'b0;
    exp_rdy = 2'b00;
    exp_cpl = 2'b00;
    if (d_rst) begin
      if (!m_active) begin
        exp_v = any;
        if (any && d_ready) exp_rdy[w] = 1'b1;
      end else if (!m_got_meta) begin
        exp_mv = d_meta_v[m_owner];
        if (exp_mv && d_cpl) exp_cpl[m_owner] = 1'b1;
      end else if (d_cpl) begin
        exp_cpl[m_owner] = 1'b1;
      end
    end
    check_eq("cache_req_v", bus.cache_req_v_o, exp_v);
    if (exp_v) check_eq("cache_req", bus.cache_req_o, pend_pkt[w]);
    if (!(d_rst && !m_active && !any)) check_eq("req_ready", bus.req_ready_o, exp_rdy);
    check_eq("meta_v", bus.cache_req_metadata_v_o, exp_mv);
    if (exp_mv) check_eq("meta", bus.cache_req_metadata_o, d_meta[m_owner]);
    check_eq("complete", bus.complete_o, exp_cpl);
    check_eq("busy", bus.busy_o, d_rst && m_active);
    check_eq("owner", bus.owner_o, d_rst ? m_owner[0] : 1'b0);

    // effect of the coming rising edge
    if (!d_rst) begin
      m_active = 0; m_got_meta = 0; m_owner = 0; m_last = 1; m_hold = -1;
    end else if (!m_active) begin
      if (!any) m_hold = -1;
      else if (d_ready) begin
        m_active = 1; m_got_meta = 0; m_owner = w; m_last = w; m_hold = -1;
        pend_v[w] = 1'b0;
      end else m_hold = w;
    end else if (!m_got_meta) begin
      if (d_meta_v[m_owner]) begin
        if (d_cpl) m_active = 0;
        else m_got_meta = 1;
      end
    end else if (d_cpl) begin
      m_active = 0;
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] pv, input logic rdy,
                       input logic [1:0] mv, input logic cpl, input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++)
        if (pv[k] && !pend_v[k]) new_req(k);
      d_rst    = r;
      d_ready  = rdy;
      d_meta_v = mv;
      d_cpl    = cpl;
      d_meta[0] = MW'($urandom);
      d_meta[1] = MW'($urandom);
      cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0; d_rst = 1'b0; d_ready = 1'b0; d_cpl = 1'b0; d_meta_v = 2'b00;
    d_meta[0] = '0; d_meta[1] = '0;
    pend_v = 2'b00; pend_pkt[0] = '0; pend_pkt[1] = '0;
    bus.req_v_i = '0; bus.req_i = '0; bus.cache_req_ready_i = 1'b0;
    bus.metadata_v_i = '0; bus.metadata_i = '0; bus.cache_req_complete_i = 1'b0;
    m_active = 0; m_got_meta = 0; m_owner = 0; m_last = 1; m_hold = -1;

    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2);  // reset
    drive(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2);  // requester 1 stalled
    drive(1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 3);  // requester 0 joins, grant stays with 1
    drive(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1);  // ready rises: handshake for 1
    drive(1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1);  // non-owner metadata ignored
    drive(1'b1, 2'b00, 1'b0, 2'b10, 1'b1, 1);  // metadata and complete coincide
    drive(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1);  // next request accepted at once
    drive(1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1);
    drive(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1);
    drive(1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1);
    drive(1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 1);  // contention: 1 wins after 0
    drive(1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1);
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1);  // reset while waiting for complete
    drive(1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 1);  // requester 0 first after reset
    drive(1'b1, 2'b00, 1'b0, 2'b01, 1'b1, 1);

    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++)
        if (!pend_v[k] && $urandom_range(0, 2) == 0) new_req(k);
      d_rst     = ($urandom_range(0, 99) != 0);
      d_ready   = 1'($urandom_range(0, 1));
      d_meta_v  = 2'($urandom);
      d_meta[0] = MW'($urandom);
      d_meta[1] = MW'($urandom);
      d_cpl     = 1'b0;
      if (d_rst && m_active) begin
        if (m_got_meta) d_cpl = ($urandom_range(0, 2) == 0);
        else            d_cpl = d_meta_v[m_owner] && ($urandom_range(0, 1) == 1);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
